mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory between two requesters:
  - the core port, driven by the multicycle datapath (fetch address, load/store address);
  - an external port, used by the program loader and debug access.
- Sits between both requesters and the memory macro.
- Drives the memory address, write data and write enable.
- Returns read-data valid strobes to each requester.
- Provides a stall signal so the control FSM can hold state while denied.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_MAX, 16, maximum consecutive locked external grants before a forced release.
- WAIT_MAX, 8, external wait cycles before the starvation guard fires (guard macro only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core granted this cycle
- c_rvalid  out  1  core read data valid
- c_stall  out  1  c_req & ~c_gnt, to control FSM
- e_req  in  1  external access request
- e_we  in  1  external write
- e_lock  in  1  hold ownership for burst
- e_addr  in  ADDR_W  external address
- e_wdata  in  DATA_W  external write data
- e_gnt  out  1  external granted this cycle
- e_rvalid  out  1  external read data valid
- rdata  out  DATA_W  shared read data (= mem_rd)
- mem_a  out  ADDR_W  memory address
- mem_wd  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rd  in  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Owner register `owner`: NONE / CORE / EXT.
- Per-cycle decision (combinational), evaluated in this order:
  - (1) owner==EXT & e_req & e_lock & lock_cnt<LOCK_MAX -> EXT.
  - (2) c_req -> CORE.
  - (3) e_req -> EXT.
  - (4) otherwise NONE.
- Grant and memory drive:
  - Grants are issued the same cycle as the decision.
  - Memory is driven from the winner's addr/wdata/we.
  - When the decision is NONE: mem_we=0, mem_a=0, mem_wd=0.
  - `owner` takes the decision at posedge.
- Lock counter:
  - Increments on each EXT grant with e_lock=1.
  - Clears on any non-EXT decision or when e_lock=0.
  - At lock_cnt==LOCK_MAX with c_req=1: core wins one cycle, the counter clears, and a lock may then resume.
  - If c_req=0 at LOCK_MAX, EXT keeps the grant and the counter saturates.
- Read valid: c_rvalid <= c_gnt & ~c_we; e_rvalid <= e_gnt & ~e_we (registered, one-cycle latency). rdata = mem_rd.
- Writes complete in the grant cycle; no write acknowledgement.
- Simultaneous c_req & e_req with no active lock: core wins; ext waits and e_req must stay asserted.
- A requester deasserting req while denied is legal; no state is retained for it.
- Reset (reset==0 at posedge):
  - owner=NONE, counters=0, c_rvalid=e_rvalid=0.
  - Combinational outputs follow the normal decision from the now-reset state.
  - A pending read valid is dropped.
- Counters saturate; they never wrap.

Optional Feature:
- Macro: MEM_ARBITER_STARVE_GUARD_EN.
- Enabled:
  - wait_cnt increments each cycle e_req & ~e_gnt, and clears on e_gnt or ~e_req.
  - At wait_cnt==WAIT_MAX, rule (3) is promoted above rule (2) for one cycle: ext wins, then the counter clears.
- Disabled: strict core priority, with no wait counter logic.

Decomposition:
- Shared types package: enum arb_owner_t {ARB_OWNER__NONE, ARB_OWNER__CORE, ARB_OWNER__EXT}, next to adr_src_t etc.
- One sub-module: arb_sat_counter (parameter MAX; ports inc, clr, cnt, at_max), instantiated for lock_cnt and wait_cnt.

Test Plan:
1. Reset behaviour: hold reset=0 for 3 cycles while c_req=e_req=1 with reads -> rvalids 0 during reset. After release, c_gnt=1 and e_gnt=0 in the first cycle.
2. Core read: c_req=1, c_we=0, c_addr=0x10, mem_rd=0xDEADBEEF the next cycle -> mem_a=0x10 and c_gnt=1 in cycle N. c_rvalid=1 and rdata=0xDEADBEEF in cycle N+1.
3. Simultaneous requests: core and ext both request at 0x20/0x40 -> core granted, c_stall=0, e_gnt=0, mem_we follows c_we. Ext is granted on the first cycle c_req=0.
4. Ext lock burst: e_lock=1 writes to 0x100..0x13C, then c_req rises mid-burst -> c_stall=1 until 16 locked grants. Then one core cycle, then ext resumes.
5. Starvation guard (macro on, WAIT_MAX=8): c_req held high, e_req high -> e_gnt=1 on the 9th cycle of waiting. Macro off -> e_gnt stays 0.
6. Reset mid-read: e_gnt read at cycle N, reset=0 at N+1 -> e_rvalid=0 at N+1 and owner=NONE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the multicycle core: memory ownership, datapath address
// source select, and a width helper for saturating counters.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_OWNER__NONE = 2'd0,
    ARB_OWNER__CORE = 2'd1,
    ARB_OWNER__EXT  = 2'd2
  } arb_owner_t;

  typedef enum logic [1:0] {
    ADR_SRC__PC      = 2'd0,
    ADR_SRC__ALU_OUT = 2'd1,
    ADR_SRC__EXT     = 2'd2
  } adr_src_t;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating event counter: counts up on inc, holds at MAX, clr has priority.
module arb_sat_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign at_max = (cnt == MAX_V);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Core/external arbiter for the unified memory with external lock bursts.
// Optional starvation guard for the external port: MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              c_req,
  input  logic                              c_we,
  input  logic [ADDR_W-1:0]                 c_addr,
  input  logic [DATA_W-1:0]                 c_wdata,
  output logic                              c_gnt,
  output logic                              c_rvalid,
  output logic                              c_stall,
  input  logic                              e_req,
  input  logic                              e_we,
  input  logic                              e_lock,
  input  logic [ADDR_W-1:0]                 e_addr,
  input  logic [DATA_W-1:0]                 e_wdata,
  output logic                              e_gnt,
  output logic                              e_rvalid,
  output logic [DATA_W-1:0]                 rdata,
  output logic [ADDR_W-1:0]                 mem_a,
  output logic [DATA_W-1:0]                 mem_wd,
  output logic                              mem_we,
  input  logic [DATA_W-1:0]                 mem_rd,
  output arb_owner_t                        dbg_owner,
  output logic [cnt_width(LOCK_MAX)-1:0]    dbg_lock_cnt,
  output logic [cnt_width(WAIT_MAX)-1:0]    dbg_wait_cnt
);

  // Handshake: a requester holds req (with addr/we/wdata stable) until it sees
  // gnt in the same cycle; a granted read returns rvalid with rdata exactly one
  // cycle later; writes finish in the grant cycle; dropping req while denied is legal.

  arb_owner_t owner_q;
  arb_owner_t dec;
  logic       lock_at_max;
  logic       lock_hold;
  logic       starve;

  assign lock_hold = (owner_q == ARB_OWNER__EXT) && e_req && e_lock && !lock_at_max;

  always_comb begin
    dec    = ARB_OWNER__NONE;
    c_gnt  = 1'b0;
    e_gnt  = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (lock_hold || starve) begin
      dec = ARB_OWNER__EXT;
    end else if (c_req) begin
      dec = ARB_OWNER__CORE;
    end else if (e_req) begin
      dec = ARB_OWNER__EXT;
    end
    unique case (dec)
      ARB_OWNER__CORE: begin
        c_gnt  = 1'b1;
        mem_a  = c_addr;
        mem_wd = c_wdata;
        mem_we = c_we;
      end
      ARB_OWNER__EXT: begin
        e_gnt  = 1'b1;
        mem_a  = e_addr;
        mem_wd = e_wdata;
        mem_we = e_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_q  <= ARB_OWNER__NONE;
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
    end else begin
      owner_q  <= dec;
      c_rvalid <= c_gnt & ~c_we;
      e_rvalid <= e_gnt & ~e_we;
    end
  end

  assign c_stall   = c_req & ~c_gnt;
  assign rdata     = mem_rd;
  assign dbg_owner = owner_q;

  // Lock run length; once it saturates a waiting core steals one cycle.
  arb_sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (e_gnt & e_lock),
    .clr    (~e_gnt | ~e_lock),
    .cnt    (dbg_lock_cnt),
    .at_max (lock_at_max)
  );

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic wait_at_max;

  arb_sat_counter #(.MAX(WAIT_MAX)) u_wait_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (e_req & ~e_gnt),
    .clr    (e_gnt | ~e_req),
    .cnt    (dbg_wait_cnt),
    .at_max (wait_at_max)
  );

  assign starve = e_req & wait_at_max;
`else
  assign dbg_wait_cnt = '0;
  assign starve       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level reference model with a read-data queue.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LOCK_MAX = 16;
  localparam int unsigned WAIT_MAX = 8;
  localparam int unsigned LW       = cnt_width(LOCK_MAX);
  localparam int unsigned WW       = cnt_width(WAIT_MAX);

  // ---------------- clock / reset / DUT ----------------
  logic              clk;
  logic              reset;
  logic              c_req, c_we, c_gnt, c_rvalid, c_stall;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              e_req, e_we, e_lock, e_gnt, e_rvalid;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [DATA_W-1:0] rdata, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  arb_owner_t        dbg_owner;
  logic [LW-1:0]     dbg_lock_cnt;
  logic [WW-1:0]     dbg_wait_cnt;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_stall(c_stall),
    .e_req(e_req), .e_we(e_we), .e_lock(e_lock), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid),
    .rdata(rdata), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd),
    .dbg_owner(dbg_owner), .dbg_lock_cnt(dbg_lock_cnt), .dbg_wait_cnt(dbg_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner: 0 none, 1 core, 2 ext. Counts are plain integers.
  int                m_owner = 0;
  int                m_lock  = 0;
  int                m_wait  = 0;
  bit                m_crv   = 1'b0;
  bit                m_erv   = 1'b0;
  bit                model_ok = 1'b0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] tb_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] next_rd;

  function automatic int decide();
    if (m_owner == 2 && e_req && e_lock && m_lock < int'(LOCK_MAX)) return 2;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    if (e_req && m_wait == int'(WAIT_MAX)) return 2;
`endif
    if (c_req) return 1;
    if (e_req) return 2;
    return 0;
  endfunction

  task automatic model_check();
    int                d;
    logic [ADDR_W-1:0] xa;
    logic [DATA_W-1:0] xwd;
    logic              xwe;
    d   = decide();
    xa  = '0;
    xwd = '0;
    xwe = 1'b0;
    if (d == 1) begin xa = c_addr; xwd = c_wdata; xwe = c_we; end
    else if (d == 2) begin xa = e_addr; xwd = e_wdata; xwe = e_we; end
    chk("m_c_gnt",    64'(c_gnt),    64'(d == 1));
    chk("m_e_gnt",    64'(e_gnt),    64'(d == 2));
    chk("m_c_stall",  64'(c_stall),  64'(c_req && d != 1));
    chk("m_mem_a",    64'(mem_a),    64'(xa));
    chk("m_mem_wd",   64'(mem_wd),   64'(xwd));
    chk("m_mem_we",   64'(mem_we),   64'(xwe));
    chk("m_c_rvalid", 64'(c_rvalid), 64'(m_crv));
    chk("m_e_rvalid", 64'(e_rvalid), 64'(m_erv));
    chk("m_owner",    64'(dbg_owner), 64'(m_owner));
    chk("m_lock_cnt", 64'(dbg_lock_cnt), 64'(m_lock));
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    chk("m_wait_cnt", 64'(dbg_wait_cnt), 64'(m_wait));
`else
    chk("m_wait_cnt", 64'(dbg_wait_cnt), 64'(0));
`endif
    if (m_crv || m_erv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_rdata: no expected read data queued (t=%0t)", $time);
      end else begin
        chk("m_rdata", 64'(rdata), 64'(exp_q.pop_front()));
      end
    end
  endtask

  // Called at the active edge with inputs still stable.
  task automatic model_update();
    int                d;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic              we;
    d       = decide();
    a       = '0;
    wd      = '0;
    we      = 1'b0;
    next_rd = $urandom;
    if (d == 1) begin a = c_addr; wd = c_wdata; we = c_we; end
    else if (d == 2) begin a = e_addr; wd = e_wdata; we = e_we; end
    if (d != 0 && we) tb_mem[a] = wd;
    if (d != 0 && !we) begin
      if (!tb_mem.exists(a)) tb_mem[a] = $urandom;
      next_rd = tb_mem[a];
    end
    if (!reset) begin
      m_owner  = 0;
      m_lock   = 0;
      m_wait   = 0;
      m_crv    = 1'b0;
      m_erv    = 1'b0;
      exp_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_owner = d;
      m_lock  = (d == 2 && e_lock) ? ((m_lock < int'(LOCK_MAX)) ? m_lock + 1 : m_lock) : 0;
      m_wait  = (e_req && d != 2) ? ((m_wait < int'(WAIT_MAX)) ? m_wait + 1 : m_wait) : 0;
      m_crv   = (d == 1) && !c_we;
      m_erv   = (d == 2) && !e_we;
      if (m_crv || m_erv) exp_q.push_back(next_rd);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_c(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd;
  endtask

  task automatic drive_e(input logic req, input logic we, input logic lock,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    e_req = req; e_we = we; e_lock = lock; e_addr = a; e_wdata = wd;
  endtask

  task automatic idle();
    drive_c(1'b0, 1'b0, '0, '0);
    drive_e(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic settle();
    #2;
  endtask

  // One clock cycle: model compare at negedge, model advance at posedge.
  task automatic step();
    @(negedge clk);
    if (model_ok) model_check();
    @(posedge clk);
    model_update();
    #1;
    mem_rd = next_rd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              c_req, c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              e_req, e_we, e_lock;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              x_cg, x_eg;
    logic [ADDR_W-1:0] x_a;
    logic [DATA_W-1:0] x_wd;
    logic              x_we, x_crv, x_erv;
  } vec_t;

  vec_t vecs[11];
  int   first_gnt;
  int   exp_first;

  initial begin
    reset  = 1'b0;
    mem_rd = '0;
    idle();

    vecs[0]  = '{1'b1,1'b0,32'h14,32'h1111, 1'b0,1'b0,1'b0,32'h0,32'h0,  1'b1,1'b0,32'h14,32'h1111,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,32'h0,32'h0,     1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0,1'b0,1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b1,32'h20,32'hAA,   1'b1,1'b0,1'b0,32'h40,32'hBB, 1'b1,1'b0,32'h20,32'hAA,1'b1,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b0,32'h24,32'hCC,   1'b1,1'b0,1'b0,32'h40,32'hBB, 1'b1,1'b0,32'h24,32'hCC,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,32'h0,32'h0,     1'b1,1'b0,1'b0,32'h40,32'hBB, 1'b0,1'b1,32'h40,32'hBB,1'b0,1'b1,1'b0};
    vecs[5]  = '{1'b0,1'b0,32'h0,32'h0,     1'b1,1'b1,1'b0,32'h44,32'h55, 1'b0,1'b1,32'h44,32'h55,1'b1,1'b0,1'b1};
    vecs[6]  = '{1'b0,1'b0,32'h0,32'h0,     1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,     1'b1,1'b1,1'b1,32'h80,32'h77, 1'b0,1'b1,32'h80,32'h77,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,32'h30,32'h0,    1'b1,1'b1,1'b1,32'h84,32'h78, 1'b0,1'b1,32'h84,32'h78,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,32'h30,32'h0,    1'b1,1'b0,1'b0,32'h88,32'h79, 1'b1,1'b0,32'h30,32'h0,1'b0,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,32'h0,32'h0,     1'b0,1'b0,1'b0,32'h0,32'h0,  1'b0,1'b0,32'h0,32'h0,1'b0,1'b1,1'b0};

    // Reset held with both ports reading: no read valids, core first after release.
    drive_c(1'b1, 1'b0, 32'h8, 32'h0);
    drive_e(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_c_rvalid", 64'(c_rvalid), 64'(0));
      chk("rst_e_rvalid", 64'(e_rvalid), 64'(0));
    end
    reset = 1'b1;
    settle();
    chk("rel_c_gnt", 64'(c_gnt), 64'(1));
    chk("rel_e_gnt", 64'(e_gnt), 64'(0));
    step();

    // Clean restart, then the vector table.
    reset = 1'b0;
    idle();
    step();
    reset = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive_c(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata);
      drive_e(vecs[i].e_req, vecs[i].e_we, vecs[i].e_lock, vecs[i].e_addr, vecs[i].e_wdata);
      settle();
      chk($sformatf("v%0d_c_gnt", i),    64'(c_gnt),    64'(vecs[i].x_cg));
      chk($sformatf("v%0d_e_gnt", i),    64'(e_gnt),    64'(vecs[i].x_eg));
      chk($sformatf("v%0d_c_stall", i),  64'(c_stall),  64'(vecs[i].c_req & ~vecs[i].x_cg));
      chk($sformatf("v%0d_mem_a", i),    64'(mem_a),    64'(vecs[i].x_a));
      chk($sformatf("v%0d_mem_wd", i),   64'(mem_wd),   64'(vecs[i].x_wd));
      chk($sformatf("v%0d_mem_we", i),   64'(mem_we),   64'(vecs[i].x_we));
      chk($sformatf("v%0d_c_rvalid", i), 64'(c_rvalid), 64'(vecs[i].x_crv));
      chk($sformatf("v%0d_e_rvalid", i), 64'(e_rvalid), 64'(vecs[i].x_erv));
      step();
    end

    // Core read with one-cycle read latency.
    tb_mem[32'h10] = 32'hDEADBEEF;
    drive_c(1'b1, 1'b0, 32'h10, 32'h0);
    drive_e(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("crd_mem_a", 64'(mem_a), 64'(32'h10));
    chk("crd_c_gnt", 64'(c_gnt), 64'(1));
    step();
    idle();
    settle();
    chk("crd_c_rvalid", 64'(c_rvalid), 64'(1));
    chk("crd_rdata",    64'(rdata),    64'(32'hDEADBEEF));
    step();

    // Simultaneous requests: core wins, ext granted once core drops.
    for (int k = 0; k < 3; k++) begin
      drive_c(1'b1, k[0], 32'h20, 32'h5A);
      drive_e(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
      settle();
      chk("sim_c_gnt",   64'(c_gnt),   64'(1));
      chk("sim_c_stall", 64'(c_stall), 64'(0));
      chk("sim_e_gnt",   64'(e_gnt),   64'(0));
      chk("sim_mem_we",  64'(mem_we),  64'(k[0]));
      step();
    end
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("sim_e_gnt_after", 64'(e_gnt), 64'(1));
    chk("sim_mem_a_after", 64'(mem_a), 64'(32'h40));
    step();

    // Locked ext burst: 16 locked grants, one core cycle, then ext resumes.
    idle();
    step();
    for (int i = 0; i < 18; i++) begin
      drive_e(1'b1, 1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'(i));
      drive_c((i >= 4 && i <= 16), 1'b0, 32'h200, 32'h0);
      settle();
      if (i < 16) begin
        chk("lk_e_gnt",   64'(e_gnt),   64'(1));
        chk("lk_mem_a",   64'(mem_a),   64'(32'h100 + 32'(4 * i)));
        chk("lk_c_stall", 64'(c_stall), 64'(i >= 4));
      end else if (i == 16) begin
        chk("lk_max_cnt",   64'(dbg_lock_cnt), 64'(LOCK_MAX));
        chk("lk_core_gnt",  64'(c_gnt), 64'(1));
        chk("lk_core_egnt", 64'(e_gnt), 64'(0));
      end else begin
        chk("lk_resume_gnt", 64'(e_gnt),        64'(1));
        chk("lk_resume_cnt", 64'(dbg_lock_cnt), 64'(0));
      end
      step();
    end
    // No core request at the limit: ext keeps the grant, counter saturates.
    drive_c(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      drive_e(1'b1, 1'b1, 1'b1, 32'h180 + 32'(4 * i), 32'(i));
      step();
    end
    settle();
    chk("sat_lock_cnt", 64'(dbg_lock_cnt), 64'(LOCK_MAX));
    chk("sat_e_gnt",    64'(e_gnt),        64'(1));
    step();

    // Starvation: core holds the memory, ext waits.
    idle();
    step();
    first_gnt = 0;
    drive_c(1'b1, 1'b0, 32'h300, 32'h0);
    drive_e(1'b1, 1'b0, 1'b0, 32'h304, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      settle();
      if (e_gnt && first_gnt == 0) first_gnt = k;
      step();
    end
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    exp_first = int'(WAIT_MAX) + 1;
`else
    exp_first = 0;
`endif
    chk("starve_first_e_gnt", 64'(first_gnt), 64'(exp_first));

    // Reset arriving right after an ext read grant drops the read valid.
    idle();
    step();
    drive_e(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    reset = 1'b0;
    settle();
    chk("rmr_e_gnt", 64'(e_gnt), 64'(1));
    step();
    idle();
    settle();
    chk("rmr_e_rvalid", 64'(e_rvalid),  64'(0));
    chk("rmr_owner",    64'(dbg_owner), 64'(ARB_OWNER__NONE));
    reset = 1'b1;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 900; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      drive_c(($urandom_range(0, 99) < (((n / 150) % 2 == 1) ? 15 : 65)),
              1'($urandom_range(0, 1)),
              32'($urandom_range(0, 31) * 4), $urandom);
      drive_e(($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 99) < 80),
              32'($urandom_range(0, 31) * 4), $urandom);
      step();
    end

    reset = 1'b1;
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
